// File: rtl/queue_drain_ctrl.sv
// Consumer-side drain sequencer: pops queue words one at a time and hands them downstream.
// Latency: dequeue 1 cycle after occupancy is seen; word valid 1 cycle after occupancy drops.
// Backpressure: m_ready_in low holds the word stable; no further dequeue until the handshake.
//
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-low reset
//   len_in, data_in     - queue occupancy and head word (already in this clock domain)
//   dequeue_out         - level-held dequeue request to the queue
//   deser_en_out        - hysteresis enable back to the deserializer
//   m_data_out, m_valid_out, m_ready_in - downstream valid/ready port
//   busy_out            - FSM not in IDLE
//   err_out             - sticky dequeue timeout flag
// Optional build macro QDRAIN_TIMEOUT_EN: bounds the REQ wait and enables err_out.
module queue_drain_ctrl #(
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 4,
  parameter int DEPTH       = 8,
  parameter int HIGH_WATER  = 6,
  parameter int LOW_WATER   = 2,
  parameter int HOLDOFF_CYC = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              dequeue_out,
  output logic              deser_en_out,
  output logic [DATA_W-1:0] m_data_out,
  output logic              m_valid_out,
  input  logic              m_ready_in,
  output logic              busy_out,
  output logic              err_out
);

  typedef enum logic [1:0] {IDLE, REQ, OUT, HOLD} state_t;

  localparam int               HO_W      = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HO_W-1:0]  HO_LOAD   = HO_W'(HOLDOFF_CYC - 1);
  localparam logic [LEN_W-1:0] HIGH_LVL  = LEN_W'(HIGH_WATER);
  localparam logic [LEN_W-1:0] LOW_LVL   = LEN_W'(LOW_WATER);
  localparam logic [LEN_W-1:0] FULL_LVL  = LEN_W'(DEPTH);

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    snap, snap_nxt;
  logic [HO_W-1:0]     ho_cnt, ho_nxt;
  logic                deq_nxt;
  logic                vld_nxt;
  logic [DATA_W-1:0]   dat_nxt;
  logic                en_nxt;

`ifdef QDRAIN_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] to_cnt, to_nxt;
  logic       err_q, err_nxt;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    ho_nxt    = ho_cnt;
    deq_nxt   = dequeue_out;
    vld_nxt   = m_valid_out;
    dat_nxt   = m_data_out;
`ifdef QDRAIN_TIMEOUT_EN
    to_nxt    = to_cnt;
    err_nxt   = err_q;
`endif
    case (state)
      IDLE: begin
        if (len_in != '0) begin
          // Snapshot occupancy: the pop is recognised when len falls below it,
          // which tolerates concurrent enqueues raising len meanwhile.
          snap_nxt  = len_in;
          deq_nxt   = 1'b1;
          state_nxt = REQ;
`ifdef QDRAIN_TIMEOUT_EN
          to_nxt    = '0;
`endif
        end
      end
      REQ: begin
        if (len_in < snap) begin
          dat_nxt   = data_in;
          vld_nxt   = 1'b1;
          deq_nxt   = 1'b0;
          state_nxt = OUT;
        end
`ifdef QDRAIN_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          deq_nxt   = 1'b0;
          err_nxt   = 1'b1;
          ho_nxt    = HO_LOAD;
          state_nxt = HOLD;
        end else begin
          to_nxt = to_cnt + 8'd1;
        end
`endif
      end
      OUT: begin
        if (m_valid_out && m_ready_in) begin
          vld_nxt   = 1'b0;
          ho_nxt    = HO_LOAD;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ho_cnt == '0) state_nxt = IDLE;
        else              ho_nxt    = ho_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Deserializer throttle: hysteresis between the water marks, full forces off.
  always_comb begin
    en_nxt = deser_en_out;
    if (len_in == FULL_LVL)      en_nxt = 1'b0;
    else if (len_in >= HIGH_LVL) en_nxt = 1'b0;
    else if (len_in <= LOW_LVL)  en_nxt = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      snap         <= '0;
      ho_cnt       <= '0;
      dequeue_out  <= 1'b0;
      m_valid_out  <= 1'b0;
      m_data_out   <= '0;
      deser_en_out <= 1'b1;
`ifdef QDRAIN_TIMEOUT_EN
      to_cnt       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      snap         <= snap_nxt;
      ho_cnt       <= ho_nxt;
      dequeue_out  <= deq_nxt;
      m_valid_out  <= vld_nxt;
      m_data_out   <= dat_nxt;
      deser_en_out <= en_nxt;
`ifdef QDRAIN_TIMEOUT_EN
      to_cnt       <= to_nxt;
      err_q        <= err_nxt;
`endif
    end
  end

  assign busy_out = (state != IDLE);

`ifdef QDRAIN_TIMEOUT_EN
  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule
